// File: rtl/bus_ext_pkg.sv
// Shared state encodings and width helpers for the serial system-bus bridges
// (uart_to_bus ingress master and bus_to_uart egress slave).
package bus_ext_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_XFER     = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4
  } bus_state_e;

  // Bits needed to hold 0..n-1 (never less than one bit).
  function automatic int width_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold 0..n inclusive.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for the UART ingress path; full/empty flags are registered
// and a push is accepted when full if a pop happens in the same cycle.
module uart_rx_fifo
  import bus_ext_pkg::*;
#(
  parameter  int N          = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int CNT_W      = count_width(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [N-1:0]     wr_data,
  output logic [N-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = width_of(FIFO_DEPTH);

  logic [N-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && !r_empty;
  assign w_do_push = push && (!r_full || w_do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10: begin
          r_count <= r_count + 1'b1;
          r_full  <= (r_count == CNT_W'(FIFO_DEPTH - 1));
          r_empty <= 1'b0;
        end
        2'b01: begin
          r_count <= r_count - 1'b1;
          r_full  <= 1'b0;
          r_empty <= (r_count == CNT_W'(1));
        end
        default: ;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;

endmodule

// File: rtl/uart_to_bus.sv
// UART ingress bridge: queued RX bytes become single serial bus writes to BASE_ADDR+offset.
// Optional ack timeout enabled by defining UART_TO_BUS_TIMEOUT_EN.
module uart_to_bus
  import bus_ext_pkg::*;
#(
  parameter int             N          = 8,
  parameter int             ADN        = 12,
  parameter int             FIFO_DEPTH = 4,
  parameter logic [ADN-1:0] BASE_ADDR  = '0,
  parameter int             ADDR_SPAN  = 16,
  parameter int             TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_valid,
  input  logic [N-1:0] rx_data,
  input  logic         bus_grant,
  input  logic         slave_ready,
  output logic         bus_request,
  output logic         valid_out,
  output logic         wren,
  output logic         addr_out,
  output logic         data_out,
  output logic         busy,
  output logic         fifo_full,
  output logic         overflow,
  output logic         error,
  output logic [2:0]   state_out
);

  localparam int OFF_W = width_of(ADDR_SPAN);
  localparam int BIT_W = width_of(ADN);
  localparam int CNT_W = count_width(FIFO_DEPTH);

  if (ADN <= N) begin : g_bad_adn
    $error("uart_to_bus: ADN must exceed N");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("uart_to_bus: TIMEOUT must be at least 1");
  end

  bus_state_e       r_state;
  logic [BIT_W-1:0] r_bit;
  logic [OFF_W-1:0] r_offset;
  logic [ADN-1:0]   r_addr_sh;
  logic [ADN-1:0]   r_data_sh;
  logic             r_bus_request;
  logic             r_valid_out;
  logic             r_addr_out;
  logic             r_data_out;
  logic             r_busy;
  logic             r_overflow;
  logic             r_error;

  logic [N-1:0]     w_head;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [CNT_W-1:0] w_count;
  logic             w_pop;
  logic             w_timeout;
  logic [ADN-1:0]   w_target;
  logic [ADN-1:0]   w_dvec;

  uart_rx_fifo #(
    .N          (N),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rx_valid),
    .pop     (w_pop),
    .wr_data (rx_data),
    .rd_data (w_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .count   (w_count)
  );

`ifdef UART_TO_BUS_TIMEOUT_EN
  localparam int TO_W = width_of(TIMEOUT);
  logic [TO_W-1:0] r_to_cnt;

  assign w_timeout = (r_state == ST_WAIT_ACK) && !slave_ready
                     && (r_to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || r_state != ST_WAIT_ACK) r_to_cnt <= '0;
    else if (!w_timeout)                 r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  // A timed-out byte is popped and discarded, just like an acknowledged one.
  assign w_pop    = ((r_state == ST_DONE) || w_timeout) && !w_fifo_empty;
  assign w_target = BASE_ADDR + ADN'(r_offset);
  // Data rides on the last N address bits, so it is left-padded with zeros.
  assign w_dvec   = {{(ADN - N){1'b0}}, w_head};

  always_ff @(posedge clk) begin
    if (reset) r_overflow <= 1'b0;
    else       r_overflow <= rx_valid && w_fifo_full && !w_pop;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_bit         <= '0;
      r_offset      <= '0;
      r_addr_sh     <= '0;
      r_data_sh     <= '0;
      r_bus_request <= 1'b0;
      r_valid_out   <= 1'b0;
      r_addr_out    <= 1'b0;
      r_data_out    <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_error <= w_timeout;
      case (r_state)
        ST_IDLE: begin
          if (w_count != '0) begin
            r_state       <= ST_REQ;
            r_bus_request <= 1'b1;
            r_busy        <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus_grant) begin
            r_state     <= ST_XFER;
            r_bit       <= '0;
            r_valid_out <= 1'b1;
            r_addr_out  <= w_target[ADN-1];
            r_data_out  <= w_dvec[ADN-1];
            r_addr_sh   <= w_target << 1;
            r_data_sh   <= w_dvec << 1;
          end
        end
        ST_XFER: begin
          if (r_bit == BIT_W'(ADN - 1)) begin
            r_state     <= ST_WAIT_ACK;
            r_valid_out <= 1'b0;
            r_addr_out  <= 1'b0;
            r_data_out  <= 1'b0;
          end else begin
            r_bit      <= r_bit + 1'b1;
            r_addr_out <= r_addr_sh[ADN-1];
            r_data_out <= r_data_sh[ADN-1];
            r_addr_sh  <= r_addr_sh << 1;
            r_data_sh  <= r_data_sh << 1;
          end
        end
        ST_WAIT_ACK: begin
          if (slave_ready) begin
            r_state       <= ST_DONE;
            r_bus_request <= 1'b0;
          end else if (w_timeout) begin
            r_state       <= ST_IDLE;
            r_bus_request <= 1'b0;
            r_busy        <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state  <= ST_IDLE;
          r_busy   <= 1'b0;
          r_offset <= (r_offset == OFF_W'(ADDR_SPAN - 1)) ? '0 : r_offset + 1'b1;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_bus_request <= 1'b0;
          r_valid_out   <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus_request = r_bus_request;
  assign valid_out   = r_valid_out;
  assign wren        = r_valid_out;
  assign addr_out    = r_addr_out;
  assign data_out    = r_data_out;
  assign busy        = r_busy;
  assign fifo_full   = w_fifo_full;
  assign overflow    = r_overflow;
  assign error       = r_error;
  assign state_out   = r_state;

endmodule

// File: tb/tb_uart_to_bus.sv
// Randomized self-checking bench for uart_to_bus: a queue/offset model predicts every
// serial write, overflow pulse and handshake phase.
module tb_uart_to_bus;

  localparam int             N          = 8;
  localparam int             ADN        = 12;
  localparam int             DEPTH      = 4;
  localparam int             SPAN       = 16;
  localparam int             TB_TIMEOUT = 10;
  localparam logic [ADN-1:0] BASE       = 12'h000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         rx_valid = 1'b0;
  logic [N-1:0] rx_data = '0;
  logic         bus_grant = 1'b0;
  logic         slave_ready = 1'b0;
  logic         bus_request, valid_out, wren, addr_out, data_out;
  logic         busy, fifo_full, overflow, error;
  logic [2:0]   state_out;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] data_q[$];
  int           model_occ = 0;
  int           model_off = 0;
  bit           ovf_chk = 1'b0;
  bit           ovf_exp = 1'b0;

  always #5 clk = ~clk;

  uart_to_bus #(
    .N          (N),
    .ADN        (ADN),
    .FIFO_DEPTH (DEPTH),
    .BASE_ADDR  (BASE),
    .ADDR_SPAN  (SPAN),
    .TIMEOUT    (TB_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .bus_grant   (bus_grant),
    .slave_ready (slave_ready),
    .bus_request (bus_request),
    .valid_out   (valid_out),
    .wren        (wren),
    .addr_out    (addr_out),
    .data_out    (data_out),
    .busy        (busy),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .error       (error),
    .state_out   (state_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serial write monitor: reassembles each frame and compares with the model.
  int             mon_k = 0;
  logic [ADN-1:0] mon_a = '0;
  logic [ADN-1:0] mon_d = '0;
  always @(negedge clk) begin
    logic [31:0] exp_a;
    logic [31:0] exp_d;
    if (reset) begin
      mon_k = 0;
    end else if (valid_out === 1'b1) begin
      check_val("wren", wren, 1'b1);
      mon_a = {mon_a[ADN-2:0], addr_out};
      mon_d = {mon_d[ADN-2:0], data_out};
      mon_k++;
    end else if (mon_k != 0) begin
      exp_a = (int'(BASE) + model_off) % (1 << ADN);
      exp_d = (data_q.size() != 0) ? 32'(data_q.pop_front()) : 32'hFFFF_FFFF;
      check_val("frame_len", mon_k, ADN);
      check_val("addr", mon_a, exp_a);
      check_val("data", mon_d, exp_d);
      check_val("error_low", error, 1'b0);
      $display("write addr=0x%03h data=0x%02h", mon_a, mon_d[N-1:0]);
      mon_k = 0;
    end
  end

  task automatic rx_strobe(input logic [N-1:0] d);
    bit acc;
    @(negedge clk);
    if (ovf_chk) check_val("overflow", overflow, ovf_exp);
    acc = (model_occ < DEPTH);
    rx_valid = 1'b1;
    rx_data  = d;
    if (acc) begin
      data_q.push_back(d);
      model_occ++;
    end
    ovf_chk = 1'b1;
    ovf_exp = !acc;
  endtask

  task automatic rx_idle();
    @(negedge clk);
    if (ovf_chk) check_val("overflow", overflow, ovf_exp);
    ovf_chk  = 1'b0;
    rx_valid = 1'b0;
  endtask

  task automatic wait_req();
    int t = 0;
    while (bus_request !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check_val("req_rise", bus_request, 1'b1);
  endtask

  task automatic grant_until_valid(input bit hold);
    int t = 0;
    bus_grant = 1'b1;
    if (hold) slave_ready = 1'b1;
    do begin
      @(negedge clk);
      t++;
    end while (valid_out !== 1'b1 && t < 8);
    bus_grant = 1'b0;
    check_val("grant_to_valid", t, 1);
    check_val("state_xfer", state_out, 3'd2);
  endtask

  task automatic wait_xfer_end();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (valid_out !== 1'b0 && t < ADN + 8);
    check_val("xfer_cycles", t, ADN);
    check_val("state_wait", state_out, 3'd3);
    check_val("req_in_wait", bus_request, 1'b1);
  endtask

  task automatic do_xfer(input int gdly, input int adly, input bit hold,
                         input bit done_push, input logic [N-1:0] done_data);
    wait_req();
    repeat (gdly) begin
      @(negedge clk);
      check_val("req_hold", bus_request, 1'b1);
      check_val("no_valid_in_req", valid_out, 1'b0);
    end
    grant_until_valid(hold);
    wait_xfer_end();
    if (!hold) begin
      repeat (adly) begin
        @(negedge clk);
        check_val("wait_hold", state_out, 3'd3);
      end
      slave_ready = 1'b1;
    end
    @(negedge clk);
    slave_ready = 1'b0;
    check_val("state_done", state_out, 3'd4);
    check_val("req_in_done", bus_request, 1'b0);
    model_occ--;
    model_off = (model_off + 1) % SPAN;
    if (done_push) begin
      rx_valid = 1'b1;
      rx_data  = done_data;
      data_q.push_back(done_data);
      model_occ++;
    end
    @(negedge clk);
    if (done_push) begin
      rx_valid = 1'b0;
      check_val("ovf_on_pop", overflow, 1'b0);
    end
    check_val("state_idle", state_out, 3'd0);
    check_val("req_low_after_done", bus_request, 1'b0);
    check_val("busy_idle", busy, 1'b0);
    check_val("fifo_full", fifo_full, model_occ == DEPTH);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_val("rst_bus_request", bus_request, 1'b0);
    check_val("rst_valid_out", valid_out, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_fifo_full", fifo_full, 1'b0);
    check_val("rst_overflow", overflow, 1'b0);
    check_val("rst_error", error, 1'b0);
    check_val("rst_state", state_out, 3'd0);
    reset = 1'b0;

    // Single byte, delayed grant and ack.
    rx_strobe(8'hA5);
    rx_idle();
    do_xfer(2, 3, 1'b0, 1'b0, '0);

    // Burst overflow with grant withheld, then a push during the DONE pop.
    for (int i = 0; i < 5; i++) rx_strobe(8'(8'h10 + i));
    rx_idle();
    check_val("full_after_burst", fifo_full, 1'b1);
    do_xfer(1, 0, 1'b0, 1'b1, 8'h3C);
    while (model_occ > 0) do_xfer(0, 1, 1'b0, 1'b0, '0);

    // slave_ready held high through the whole transfer.
    rx_strobe(8'h5A);
    rx_idle();
    do_xfer(0, 0, 1'b1, 1'b0, '0);

    // Seventeen single writes cross the address-window wrap.
    for (int i = 0; i < 17; i++) begin
      rx_strobe(8'($urandom));
      rx_idle();
      do_xfer(0, 0, 1'b0, 1'b0, '0);
    end

    // Randomized rounds of bursts and handshake delays.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        rx_strobe(8'($urandom));
        if ($urandom_range(0, 1) == 1) rx_idle();
      end
      rx_idle();
      check_val("round_full", fifo_full, model_occ == DEPTH);
      while (model_occ > 0)
        do_xfer($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, '0);
    end

`ifdef UART_TO_BUS_TIMEOUT_EN
    // Missing ack: byte dropped after TIMEOUT cycles, address reused.
    rx_strobe(8'h11);
    rx_strobe(8'h22);
    rx_idle();
    wait_req();
    grant_until_valid(1'b0);
    wait_xfer_end();
    repeat (TB_TIMEOUT - 1) @(negedge clk);
    check_val("error_before_timeout", error, 1'b0);
    check_val("state_before_timeout", state_out, 3'd3);
    @(negedge clk);
    check_val("error_pulse", error, 1'b1);
    check_val("state_after_timeout", state_out, 3'd0);
    check_val("req_after_timeout", bus_request, 1'b0);
    model_occ--;
    @(negedge clk);
    check_val("error_one_cycle", error, 1'b0);
    do_xfer(0, 0, 1'b0, 1'b0, '0);
`endif

    // Reset in the middle of a transfer flushes everything.
    rx_strobe(8'hC3);
    rx_strobe(8'h96);
    rx_idle();
    wait_req();
    grant_until_valid(1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_valid_out", valid_out, 1'b0);
    check_val("abort_bus_request", bus_request, 1'b0);
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_fifo_full", fifo_full, 1'b0);
    check_val("abort_state", state_out, 3'd0);
    data_q.delete();
    model_occ = 0;
    model_off = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("flushed_no_req", bus_request, 1'b0);
    rx_strobe(8'h7E);
    rx_idle();
    do_xfer(1, 1, 1'b0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
